bsg_manycore_region_loader: RTL and testbench

//  Parametrised next-generation SPMD program loader. Streams a word-addressed program image from a

---
 rtl/bsg_manycore_loader_pkg.sv | 49 ++++
 rtl/bsg_manycore_loader_tile_iter.sv | 76 +++++++
 rtl/bsg_manycore_region_loader.sv | 173 +++++++++++++++++
 tb/tb_bsg_manycore_region_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_loader_pkg.sv
// Shared types and constants for the manycore region loader: FSM states, packet op codes,
// config-space offsets, and the parametrised packet declaration macro.
`define BSG_MANYCORE_PACKET_WIDTH(aw, dw, xw, yw) ((aw) + 2 + 4 + (dw) + 2 * (yw) + 2 * (xw))

`define DECLARE_BSG_MANYCORE_PACKET_S(aw, dw, xw, yw) \
    typedef struct packed { \
        logic [(aw)-1:0]         addr; \
        bsg_manycore_packet_op_e op; \
        logic [3:0]              op_ex; \
        logic [(dw)-1:0]         payload; \
        logic [(yw)-1:0]         src_y_cord; \
        logic [(xw)-1:0]         src_x_cord; \
        logic [(yw)-1:0]         y_cord; \
        logic [(xw)-1:0]         x_cord; \
    } bsg_manycore_packet_s

package bsg_manycore_loader_pkg;

    localparam int unsigned max_tiles_gp = 1024;
    localparam int unsigned tile_idx_width_gp = $clog2(max_tiles_gp);

    typedef enum logic [2:0] {
        e_idle,
        e_load,
        e_drain,
        e_unfreeze,
        e_arb_cfg,
        e_done
    } loader_state_e;

    typedef enum logic [1:0] {
        e_remote_load  = 2'b00,
        e_remote_store = 2'b01,
        e_remote_amo   = 2'b10
    } bsg_manycore_packet_op_e;

    localparam logic [3:0] op_ex_all_bytes_gp = 4'b1111;
    localparam logic [3:0] op_ex_none_gp      = 4'b0000;

    // Word offsets inside tile config space (selected by the address MSB).
    localparam int unsigned cfg_unfreeze_offset_gp = 0;
    localparam int unsigned cfg_arb_offset_gp      = 4;

    // Counter width that stays legal for a count of one.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_manycore_loader_tile_iter.sv
// Row-major tile walker with a per-tile word counter; exposes the linear tile id,
// skip-mask lookup and last-word / last-tile flags to the loader FSM.
module bsg_manycore_loader_tile_iter
    import bsg_manycore_loader_pkg::*;
#(
    parameter int unsigned             cols_p      = 2,
    parameter int unsigned             rows_p      = 2,
    parameter int unsigned             mem_words_p = 4,
    parameter logic [max_tiles_gp-1:0] skip_mask_p = '0,
    localparam int unsigned col_w_lp  = safe_clog2(cols_p),
    localparam int unsigned row_w_lp  = safe_clog2(rows_p),
    localparam int unsigned word_w_lp = safe_clog2(mem_words_p),
    localparam int unsigned tile_w_lp = safe_clog2(cols_p * rows_p)
)(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 step_word_i,
    input  logic                 step_tile_i,
    output logic [col_w_lp-1:0]  col_o,
    output logic [row_w_lp-1:0]  row_o,
    output logic [word_w_lp-1:0] word_o,
    output logic [tile_w_lp-1:0] tile_o,
    output logic                 skip_o,
    output logic                 last_word_o,
    output logic                 last_tile_o
);

    logic [col_w_lp-1:0]  col_q;
    logic [row_w_lp-1:0]  row_q;
    logic [word_w_lp-1:0] word_q;
    logic [tile_w_lp-1:0] tile_q;

    assign col_o       = col_q;
    assign row_o       = row_q;
    assign word_o      = word_q;
    assign tile_o      = tile_q;
    assign last_word_o = (word_q == word_w_lp'(mem_words_p - 1));
    assign last_tile_o = (tile_q == tile_w_lp'(cols_p * rows_p - 1));
    assign skip_o      = skip_mask_p[tile_idx_width_gp'(tile_q)];

    // The linear id is kept as its own counter so no multiply is needed.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            col_q  <= '0;
            row_q  <= '0;
            word_q <= '0;
            tile_q <= '0;
        end else if (clear_i) begin
            col_q  <= '0;
            row_q  <= '0;
            word_q <= '0;
            tile_q <= '0;
        end else if (step_tile_i) begin
            word_q <= '0;
            if (last_tile_o) begin
                col_q  <= '0;
                row_q  <= '0;
                tile_q <= '0;
            end else begin
                tile_q <= tile_q + tile_w_lp'(1);
                if (col_q == col_w_lp'(cols_p - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + row_w_lp'(1);
                end else begin
                    col_q <= col_q + col_w_lp'(1);
                end
            end
        end else if (step_word_i) begin
            word_q <= word_q + word_w_lp'(1);
        end
    end

endmodule

// File: rtl/bsg_manycore_region_loader.sv
// SPMD program loader: streams a ROM image into every tile of a rectangular region, drains
// outstanding stores, then unfreezes each tile and optionally writes its arbiter config.
module bsg_manycore_region_loader
    import bsg_manycore_loader_pkg::*;
#(
    parameter int unsigned             addr_width_p   = 30,
    parameter int unsigned             data_width_p   = 32,
    parameter int unsigned             x_cord_width_p = 4,
    parameter int unsigned             y_cord_width_p = 4,
    parameter int unsigned             mem_words_p    = 4,
    parameter int unsigned             tile_id_word_p = 0,
    parameter int unsigned             origin_x_p     = 0,
    parameter int unsigned             origin_y_p     = 0,
    parameter int unsigned             load_cols_p    = 2,
    parameter int unsigned             load_rows_p    = 2,
    parameter logic [max_tiles_gp-1:0] skip_mask_p    = '0,
    parameter int unsigned             max_credits_p  = 16,
    parameter bit                      arb_cfg_en_p   = 1'b1,
    parameter logic [data_width_p-1:0] arb_cfg_val_p  = '0
)(
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    output logic [`BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)-1:0] packet_o,
    output logic                      v_o,
    input  logic                      ready_i,
    input  logic                      credit_v_i,
    output logic [addr_width_p-1:0]   rom_addr_o,
    input  logic [data_width_p-1:0]   rom_data_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic                      busy_o,
    output logic                      done_o
);

    `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

    localparam int unsigned col_w_lp  = safe_clog2(load_cols_p);
    localparam int unsigned row_w_lp  = safe_clog2(load_rows_p);
    localparam int unsigned word_w_lp = safe_clog2(mem_words_p);
    localparam int unsigned tile_w_lp = safe_clog2(load_cols_p * load_rows_p);
    localparam int unsigned cred_w_lp = safe_clog2(max_credits_p + 1);

    localparam logic [cred_w_lp-1:0]    max_credits_lp = cred_w_lp'(max_credits_p);
    localparam logic [word_w_lp-1:0]    tile_id_word_lp = word_w_lp'(tile_id_word_p);
    localparam logic [addr_width_p-1:0] cfg_space_lp = {1'b1, {(addr_width_p-1){1'b0}}};

    loader_state_e        state_q;
    logic [cred_w_lp-1:0] credits_q;

    logic [col_w_lp-1:0]  col;
    logic [row_w_lp-1:0]  row;
    logic [word_w_lp-1:0] word;
    logic [tile_w_lp-1:0] tile;
    logic                 skip, last_word, last_tile;
    logic                 in_phase, send, step_word, step_tile, phase_done, start_load;

    assign in_phase   = state_q inside {e_load, e_unfreeze, e_arb_cfg};
    assign v_o        = in_phase & ~skip & (credits_q != '0);
    assign send       = v_o & ready_i;
    assign start_load = (state_q == e_idle) & start_i;

    // A skipped tile moves on every cycle; in LOAD a sent tile moves on only after its last word.
    assign step_tile  = in_phase & (skip | (send & ((state_q != e_load) | last_word)));
    assign step_word  = (state_q == e_load) & send & ~last_word;
    assign phase_done = step_tile & last_tile;

    bsg_manycore_loader_tile_iter #(
        .cols_p      (load_cols_p),
        .rows_p      (load_rows_p),
        .mem_words_p (mem_words_p),
        .skip_mask_p (skip_mask_p)
    ) u_iter (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (start_load),
        .step_word_i (step_word),
        .step_tile_i (step_tile),
        .col_o       (col),
        .row_o       (row),
        .word_o      (word),
        .tile_o      (tile),
        .skip_o      (skip),
        .last_word_o (last_word),
        .last_tile_o (last_tile)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                e_idle: if (start_i) begin
                    state_q <= e_load;
                    busy_o  <= 1'b1;
                end
                e_load: if (phase_done) state_q <= e_drain;
                e_drain: if (credits_q == max_credits_lp) state_q <= e_unfreeze;
                e_unfreeze: if (phase_done) begin
                    if (arb_cfg_en_p) begin
                        state_q <= e_arb_cfg;
                    end else begin
                        state_q <= e_done;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                e_arb_cfg: if (phase_done) begin
                    state_q <= e_done;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
                e_done: state_q <= e_done;
                default: begin
                    state_q <= e_idle;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    // Credits are loaded on start; a return at the ceiling is dropped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q <= '0;
        end else if (state_q == e_idle) begin
            if (start_i) credits_q <= max_credits_lp;
        end else if (send && !credit_v_i) begin
            credits_q <= credits_q - cred_w_lp'(1);
        end else if (!send && credit_v_i && (credits_q != max_credits_lp)) begin
            credits_q <= credits_q + cred_w_lp'(1);
        end
    end

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(credit_v_i && !send && (credits_q == max_credits_lp)));

    bsg_manycore_packet_s pkt;

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        pkt            = '0;
        pkt.op         = e_remote_store;
        pkt.src_x_cord = my_x_i;
        pkt.src_y_cord = my_y_i;
        pkt.x_cord     = x_cord_width_p'(origin_x_p) + x_cord_width_p'(col);
        pkt.y_cord     = y_cord_width_p'(origin_y_p) + y_cord_width_p'(row);
        case (state_q)
            e_unfreeze: begin
                pkt.addr    = cfg_space_lp | addr_width_p'(cfg_unfreeze_offset_gp);
                pkt.op_ex   = op_ex_none_gp;
                pkt.payload = '0;
            end
            e_arb_cfg: begin
                pkt.addr    = cfg_space_lp | addr_width_p'(cfg_arb_offset_gp);
                pkt.op_ex   = op_ex_all_bytes_gp;
                pkt.payload = arb_cfg_val_p;
            end
            default: begin
                pkt.addr    = addr_width_p'(word);
                pkt.op_ex   = op_ex_all_bytes_gp;
                pkt.payload = (word == tile_id_word_lp) ? data_width_p'(tile) : rom_data_i;
            end
        endcase
    end

    assign packet_o   = pkt;
    assign rom_addr_o = addr_width_p'(word);

endmodule

// File: tb/tb_bsg_manycore_region_loader.sv
// Scoreboard bench: two loader instances (full 2x2 with arbiter config; skipped tile, two
// credits, no arbiter config) under random ready/credit stalls and a mid-load reset.
module tb_bsg_manycore_region_loader;

    typedef struct packed {
        logic [29:0] addr;
        logic [1:0]  op;
        logic [3:0]  op_ex;
        logic [31:0] payload;
        logic [3:0]  src_y;
        logic [3:0]  src_x;
        logic [3:0]  y;
        logic [3:0]  x;
    } pkt_t;

    localparam logic [31:0] ARB_VAL = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start    [2];
    logic [83:0] pkt      [2];
    logic        v        [2];
    logic        ready    [2];
    logic        credit_v [2];
    logic [29:0] rom_addr [2];
    logic [31:0] rom_data [2];
    logic        busy     [2];
    logic        done     [2];
    logic [3:0]  my_x     [2];
    logic [3:0]  my_y     [2];
    logic [31:0] rom_mem  [2][4];

    int   n_vec = 0;
    int   n_mis = 0;
    pkt_t exp_q [2][$];
    int   ready_pct [2], credit_pct [2], credit_grant [2], credit_used [2];
    bit   withhold [2];
    int   outst [2], n_sent [2], loads_sent [2], credits_ret [2];
    bit   prev_stall [2];
    pkt_t prev_pkt [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bsg_manycore_region_loader #(
            .addr_width_p   (30),
            .data_width_p   (32),
            .x_cord_width_p (4),
            .y_cord_width_p (4),
            .mem_words_p    (4),
            .tile_id_word_p (g == 0 ? 1 : 3),
            .origin_x_p     (g == 0 ? 1 : 3),
            .origin_y_p     (g == 0 ? 2 : 1),
            .load_cols_p    (2),
            .load_rows_p    (2),
            .skip_mask_p    (g == 0 ? 1024'd0 : 1024'd2),
            .max_credits_p  (g == 0 ? 16 : 2),
            .arb_cfg_en_p   (g == 0),
            .arb_cfg_val_p  (ARB_VAL)
        ) u_dut (
            .clk_i      (clk),
            .reset_n_i  (rst_n),
            .start_i    (start[g]),
            .packet_o   (pkt[g]),
            .v_o        (v[g]),
            .ready_i    (ready[g]),
            .credit_v_i (credit_v[g]),
            .rom_addr_o (rom_addr[g]),
            .rom_data_i (rom_data[g]),
            .my_x_i     (my_x[g]),
            .my_y_i     (my_y[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g])
        );
    end

    always_comb begin
        for (int g = 0; g < 2; g++) rom_data[g] = rom_mem[g][rom_addr[g][1:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input int g, input int x, input int y, input logic [29:0] addr,
                                input logic [3:0] op_ex, input logic [31:0] data);
        pkt_t p;
        p.addr = addr; p.op = 2'b01; p.op_ex = op_ex; p.payload = data;
        p.src_x = my_x[g]; p.src_y = my_y[g]; p.x = 4'(x); p.y = 4'(y);
        return p;
    endfunction

    // Reference: whole transaction list for one start, from the region description.
    task automatic push_expected(input int g);
        int       ox   = (g == 0) ? 1 : 3;
        int       oy   = (g == 0) ? 2 : 1;
        int       tidw = (g == 0) ? 1 : 3;
        bit [3:0] skip = (g == 0) ? 4'b0000 : 4'b0010;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (!skip[r*2+c])
                    for (int w = 0; w < 4; w++)
                        exp_q[g].push_back(mk(g, ox + c, oy + r, 30'(w), 4'hF,
                                              (w == tidw) ? 32'(r*2+c) : rom_mem[g][w]));
        for (int t = 0; t < 4; t++)
            if (!skip[t]) exp_q[g].push_back(mk(g, ox + t % 2, oy + t / 2, 30'h2000_0000, 4'h0, 32'h0));
        if (g == 0)
            for (int t = 0; t < 4; t++)
                exp_q[g].push_back(mk(g, ox + t % 2, oy + t / 2, 30'h2000_0004, 4'hF, ARB_VAL));
    endtask

    // Network side: random ready, credits returned only for stores actually outstanding.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            ready[g]    = ($urandom_range(99) < ready_pct[g]);
            credit_v[g] = 1'b0;
            if (rst_n && outst[g] > 0) begin
                if (!withhold[g]) begin
                    credit_v[g] = ($urandom_range(99) < credit_pct[g]);
                end else if (credit_used[g] < credit_grant[g]) begin
                    credit_v[g] = 1'b1;
                    credit_used[g]++;
                end
            end
        end
    end

    // Monitor: inputs are stable here, so v&ready at this point is a send on the next edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pkt_t p;
            if (!rst_n) begin
                outst[g] = 0; loads_sent[g] = 0; credits_ret[g] = 0; prev_stall[g] = 0;
                continue;
            end
            p = pkt[g];
            if (v[g]) begin
                if (prev_stall[g]) check($sformatf("hold_stable%0d", g), p, prev_pkt[g]);
                if (p.addr == 30'h2000_0000)
                    check($sformatf("drain_before_unfreeze%0d", g), 128'(credits_ret[g] >= loads_sent[g]), 128'(1));
            end
            if (v[g] && ready[g]) begin
                if (exp_q[g].size() == 0) begin
                    check($sformatf("unexpected_pkt%0d", g), p, 128'(0));
                end else begin
                    check($sformatf("pkt%0d", g), p, exp_q[g].pop_front());
                end
                n_sent[g]++;
                outst[g]++;
                if (!p.addr[29]) loads_sent[g]++;
            end
            if (credit_v[g]) begin
                outst[g]--;
                credits_ret[g]++;
            end
            prev_stall[g] = v[g] && !ready[g];
            prev_pkt[g]   = p;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input bit s0, input bit s1);
        cycles(1);
        start[0] = s0; start[1] = s1;
        cycles(1);
        start[0] = 1'b0; start[1] = 1'b0;
    endtask

    task automatic wait_done_and_check(input string tag);
        for (int c = 0; c < 20000; c++) begin
            if (done[0] && done[1]) break;
            @(posedge clk);
        end
        cycles(4);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s_done%0d", tag, g), done[g], 1'b1);
            check($sformatf("%s_busy%0d", tag, g), busy[g], 1'b0);
            check($sformatf("%s_left%0d", tag, g), exp_q[g].size(), 0);
        end
    endtask

    initial begin
        int base0, base1;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0; ready[g] = 1'b0; credit_v[g] = 1'b0;
            ready_pct[g] = 100; credit_pct[g] = 100; withhold[g] = 1'b0;
            credit_grant[g] = 0; credit_used[g] = 0; n_sent[g] = 0;
            outst[g] = 0; loads_sent[g] = 0; credits_ret[g] = 0; prev_stall[g] = 1'b0;
            for (int w = 0; w < 4; w++) rom_mem[g][w] = $urandom;
        end
        my_x[0] = 4'hE; my_y[0] = 4'hF; my_x[1] = 4'h5; my_y[1] = 4'h6;

        cycles(3);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_v%0d", g), v[g], 1'b0);
            check($sformatf("rst_busy%0d", g), busy[g], 1'b0);
            check($sformatf("rst_done%0d", g), done[g], 1'b0);
            check($sformatf("rst_pkt_known%0d", g), $isunknown(pkt[g]), 1'b0);
        end
        rst_n = 1'b1;

        // Instant network for instance 0; instance 1 gets no credits back.
        withhold[1] = 1'b1;
        push_expected(0);
        push_expected(1);
        pulse_start(1'b1, 1'b1);
        check("busy_after_start0", busy[0], 1'b1);
        cycles(20);
        check("credit_limit_sent", n_sent[1], 2);
        check("credit_limit_v", v[1], 1'b0);
        credit_grant[1]++;
        cycles(10);
        check("one_credit_sent", n_sent[1], 3);
        check("one_credit_v", v[1], 1'b0);
        withhold[1] = 1'b0;
        ready_pct[0] = 60; ready_pct[1] = 60; credit_pct[0] = 50; credit_pct[1] = 50;
        wait_done_and_check("run1");

        // Start while DONE must be ignored.
        base0 = n_sent[0]; base1 = n_sent[1];
        pulse_start(1'b1, 1'b1);
        cycles(20);
        check("done_start_ignored0", n_sent[0], base0);
        check("done_start_ignored1", n_sent[1], base1);
        check("done_sticky0", done[0], 1'b1);
        check("done_sticky1", done[1], 1'b1);

        // Reset mid-load, then a clean restart from tile 0 word 0.
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        check("rst_clears_done", done[0], 1'b0);
        push_expected(0);
        push_expected(1);
        base0 = n_sent[0];
        pulse_start(1'b1, 1'b1);
        for (int c = 0; c < 300; c++) begin
            if (n_sent[0] >= base0 + 5) break;
            @(posedge clk);
        end
        #2;
        check("midload_progress", 128'(n_sent[0] >= base0 + 5), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_drops_v0", v[0], 1'b0);
        check("rst_drops_v1", v[1], 1'b0);
        check("rst_drops_busy0", busy[0], 1'b0);
        exp_q[0].delete();
        exp_q[1].delete();
        cycles(2);
        rst_n = 1'b1;
        push_expected(0);
        push_expected(1);
        pulse_start(1'b1, 1'b1);
        wait_done_and_check("run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
